// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode seven-segment scanner with a per-frame shadow copy of the BCD digits.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses a zero tens-of-minutes digit.
module seg7_scan_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] num0,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [3:0] num3,
    input  logic       colon_on,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    digit_t           idx, idx_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             tick;
    logic [3:0]       sh0, sh1, sh2, sh3;
    logic [3:0]       sh0_nx, sh1_nx, sh2_nx, sh3_nx;
    logic [3:0]       cur_digit;
    logic             blank;
    logic [3:0]       an_nx;
    logic [6:0]       seg_nx;
    logic             dp_nx;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= DIG0;
            sh0 <= '0;
            sh1 <= '0;
            sh2 <= '0;
            sh3 <= '0;
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else begin
            cnt <= cnt_nx;
            idx <= idx_nx;
            sh0 <= sh0_nx;
            sh1 <= sh1_nx;
            sh2 <= sh2_nx;
            sh3 <= sh3_nx;
            an  <= an_nx;
            seg <= seg_nx;
            dp  <= dp_nx;
        end
    end

    // Prescaler, slot index and frame capture.
    always_comb begin
        tick   = (cnt == CNT_LAST);
        cnt_nx = cnt + 1'b1;
        idx_nx = idx;
        sh0_nx = sh0;
        sh1_nx = sh1;
        sh2_nx = sh2;
        sh3_nx = sh3;
        if (tick) begin
            cnt_nx = '0;
            case (idx)
                DIG0:    idx_nx = DIG1;
                DIG1:    idx_nx = DIG2;
                DIG2:    idx_nx = DIG3;
                default: idx_nx = DIG0;
            endcase
            // Inputs are sampled only on the wrap so a whole frame shows one coherent time.
            if (idx == DIG3) begin
                sh0_nx = num0;
                sh1_nx = num1;
                sh2_nx = num2;
                sh3_nx = num3;
            end
        end
    end

    // Output stage, computed from the current state and registered one cycle later.
    always_comb begin
        blank = (cnt < BLANK_LIM);
        case (idx)
            DIG0:    cur_digit = sh0;
            DIG1:    cur_digit = sh1;
            DIG2:    cur_digit = sh2;
            default: cur_digit = sh3;
        endcase

        seg_nx = seg_decode(cur_digit);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx == DIG3 && sh3 == 4'd0) begin
            seg_nx = '1;
        end
`endif

        an_nx = '1;
        if (!blank) begin
            case (idx)
                DIG0:    an_nx = 4'b1110;
                DIG1:    an_nx = 4'b1101;
                DIG2:    an_nx = 4'b1011;
                default: an_nx = 4'b0111;
            endcase
        end

        dp_nx = ~((idx == DIG2) && colon_on && !blank);
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux with REFRESH_DIV=4, BLANK_CYC=1.
// Output state s is visible after posedge s+1 following reset release: cnt=s%4, idx=(s/4)%4.
module tb_seg7_scan_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] num0, num1, num2, num3;
    logic       colon_on;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int tests = 0;
    int fails = 0;
    int edges = 0;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .REFRESH_DIV(4),
        .BLANK_CYC  (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .num0    (num0),
        .num1    (num1),
        .num2    (num2),
        .num3    (num3),
        .colon_on(colon_on),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    task automatic step();
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic goto_state(input int s);
        while (edges < s + 1) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        num0 = 4'd0; num1 = 4'd0; num2 = 4'd0; num3 = 4'd0;
        colon_on = 1'b0;
        @(negedge clk);
        repeat (3) step();
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got=%b exp=%b", an, 4'b1111); end
        tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg got=%b exp=%b", seg, 7'b1111111); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got=%b exp=%b", dp, 1'b1); end
        reset = 1'b0;
        edges = 0;
        goto_state(0);
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL first_blank_an got=%b exp=%b", an, 4'b1111); end
        tests++; if (seg !== 7'b1000000) begin fails++; $display("FAIL first_blank_seg got=%b exp=%b", seg, 7'b1000000); end
        goto_state(1);
        tests++; if (an !== 4'b1110) begin fails++; $display("FAIL first_slot_an got=%b exp=%b", an, 4'b1110); end
        tests++; if (seg !== 7'b1000000) begin fails++; $display("FAIL first_slot_seg got=%b exp=%b", seg, 7'b1000000); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL first_slot_dp got=%b exp=%b", dp, 1'b1); end
    endtask

    task automatic test_digits();
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        num0 = 4'd4; num1 = 4'd3; num2 = 4'd2; num3 = 4'd1;
        colon_on = 1'b1;
        for (int s = 16; s < 32; s++) begin
            int c;
            int i;
            c = s % 4;
            i = (s / 4) % 4;
            goto_state(s);
            exp_an  = (c == 0) ? 4'b1111 : an_tab[i];
            exp_seg = seg_tab[i];
            exp_dp  = (i == 2 && c != 0) ? 1'b0 : 1'b1;
            tests++; if (an !== exp_an) begin fails++; $display("FAIL digits_an s=%0d got=%b exp=%b", s, an, exp_an); end
            tests++; if (seg !== exp_seg) begin fails++; $display("FAIL digits_seg s=%0d got=%b exp=%b", s, seg, exp_seg); end
            tests++; if (dp !== exp_dp) begin fails++; $display("FAIL digits_dp s=%0d got=%b exp=%b", s, dp, exp_dp); end
        end
    endtask

    task automatic test_midframe();
        goto_state(33);
        num2 = 4'd6;
        goto_state(37);
        num0 = 4'd9;
        goto_state(38);
        tests++; if (seg !== 7'b0110000) begin fails++; $display("FAIL mid_d1_seg got=%b exp=%b", seg, 7'b0110000); end
        goto_state(41);
        tests++; if (seg !== 7'b0100100) begin fails++; $display("FAIL mid_d2_old_seg got=%b exp=%b", seg, 7'b0100100); end
        tests++; if (an !== 4'b1011) begin fails++; $display("FAIL mid_d2_an got=%b exp=%b", an, 4'b1011); end
        goto_state(47);
        tests++; if (seg !== 7'b1111001) begin fails++; $display("FAIL mid_d3_seg got=%b exp=%b", seg, 7'b1111001); end
        goto_state(49);
        tests++; if (seg !== 7'b0010000) begin fails++; $display("FAIL wrap_d0_seg got=%b exp=%b", seg, 7'b0010000); end
        tests++; if (an !== 4'b1110) begin fails++; $display("FAIL wrap_d0_an got=%b exp=%b", an, 4'b1110); end
        goto_state(57);
        tests++; if (seg !== 7'b0000010) begin fails++; $display("FAIL wrap_d2_seg got=%b exp=%b", seg, 7'b0000010); end
    endtask

    task automatic test_capture_edge();
        goto_state(62);
        num1 = 4'hA;
        num2 = 4'hF;
        goto_state(63);
        num0 = 4'd5;
        goto_state(65);
        tests++; if (seg !== 7'b0010000) begin fails++; $display("FAIL post_capture_d0_seg got=%b exp=%b", seg, 7'b0010000); end
        goto_state(69);
        tests++; if (an !== 4'b1101) begin fails++; $display("FAIL code_a_an got=%b exp=%b", an, 4'b1101); end
        tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL code_a_seg got=%b exp=%b", seg, 7'b1111111); end
        goto_state(73);
        tests++; if (an !== 4'b1011) begin fails++; $display("FAIL code_f_an got=%b exp=%b", an, 4'b1011); end
        tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL code_f_seg got=%b exp=%b", seg, 7'b1111111); end
        tests++; if (dp !== 1'b0) begin fails++; $display("FAIL code_f_dp got=%b exp=%b", dp, 1'b0); end
        goto_state(77);
        tests++; if (seg !== 7'b1111001) begin fails++; $display("FAIL code_d3_seg got=%b exp=%b", seg, 7'b1111001); end
    endtask

    task automatic test_reset_mid();
        goto_state(89);
        reset = 1'b1;
        step();
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL rst_mid_an got=%b exp=%b", an, 4'b1111); end
        tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL rst_mid_seg got=%b exp=%b", seg, 7'b1111111); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL rst_mid_dp got=%b exp=%b", dp, 1'b1); end
        reset = 1'b0;
        edges = 0;
        goto_state(0);
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL rst_restart_an got=%b exp=%b", an, 4'b1111); end
        tests++; if (seg !== 7'b1000000) begin fails++; $display("FAIL rst_restart_seg got=%b exp=%b", seg, 7'b1000000); end
        goto_state(1);
        tests++; if (an !== 4'b1110) begin fails++; $display("FAIL rst_d0_an got=%b exp=%b", an, 4'b1110); end
        goto_state(5);
        tests++; if (an !== 4'b1101) begin fails++; $display("FAIL rst_d1_an got=%b exp=%b", an, 4'b1101); end
        tests++; if (seg !== 7'b1000000) begin fails++; $display("FAIL rst_d1_seg got=%b exp=%b", seg, 7'b1000000); end
        goto_state(9);
        tests++; if (seg !== 7'b1000000) begin fails++; $display("FAIL rst_d2_seg got=%b exp=%b", seg, 7'b1000000); end
        tests++; if (dp !== 1'b0) begin fails++; $display("FAIL rst_d2_dp got=%b exp=%b", dp, 1'b0); end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp_d3;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_d3 = 7'b1111111;
`else
        exp_d3 = 7'b1000000;
`endif
        num0 = 4'd0; num1 = 4'd0; num2 = 4'd5; num3 = 4'd0;
        colon_on = 1'b0;
        goto_state(25);
        tests++; if (seg !== 7'b0010010) begin fails++; $display("FAIL lz_d2_seg got=%b exp=%b", seg, 7'b0010010); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL colon_off_dp got=%b exp=%b", dp, 1'b1); end
        goto_state(26);
        colon_on = 1'b1;
        goto_state(27);
        tests++; if (dp !== 1'b0) begin fails++; $display("FAIL colon_live_dp got=%b exp=%b", dp, 1'b0); end
        goto_state(28);
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL lz_blank_an got=%b exp=%b", an, 4'b1111); end
        goto_state(29);
        tests++; if (an !== 4'b0111) begin fails++; $display("FAIL lz_d3_an got=%b exp=%b", an, 4'b0111); end
        tests++; if (seg !== exp_d3) begin fails++; $display("FAIL lz_d3_seg got=%b exp=%b", seg, exp_d3); end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_midframe();
        test_capture_edge();
        test_reset_mid();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
